// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation codes, FSM states
// and small operation-class decoders.
package hilo_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } muldiv_state_t;

  function automatic logic op_is_mul(input muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_div_restoring_core.sv
// Unsigned restoring divider: one quotient bit per i_step, DATA_W steps total.
// o_done stays set once the last bit is produced until the next start/clear.
module div_restoring_core
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_start,
  input  logic              i_clear,
  input  logic              i_step,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_quotient,
  output logic [DATA_W-1:0] o_remainder,
  output logic              o_done
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_dsor;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_done;

  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_diff;

  // Trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    w_shift = {r_rem, r_quo[DATA_W-1]};
    w_diff  = w_shift - {1'b0, r_dsor};
  end

  // Quotient bits shift in from the right as dividend bits shift out the top
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dsor <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_clear) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dsor <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_dsor <= i_divisor;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_step && !r_done) begin
      if (w_diff[DATA_W]) begin
        r_rem <= w_shift[DATA_W-1:0];
        r_quo <= {r_quo[DATA_W-2:0], 1'b0};
      end else begin
        r_rem <= w_diff[DATA_W-1:0];
        r_quo <= {r_quo[DATA_W-2:0], 1'b1};
      end
      if (r_cnt == CNT_W'(DATA_W - 1)) begin
        r_done <= 1'b1;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;
  assign o_done      = r_done;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Define MULDIV_FAST_MULT_EN for a single-cycle combinational multiplier.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  muldiv_state_t       r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_ready;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic [DATA_W-1:0]   r_mcand;
  logic [DATA_W-1:0]   r_src_a;
  logic [2*DATA_W-1:0] r_prod;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_dbz;
  logic                r_ovf;
  logic                r_op_div;

  muldiv_op_t          w_op;
  logic                w_accept;
  logic                w_signed;
  logic                w_start_mul;
  logic                w_start_div;
  logic                w_last;
  logic [DATA_W-1:0]   w_mag_a;
  logic [DATA_W-1:0]   w_mag_b;
  logic [DATA_W-1:0]   w_quo;
  logic [DATA_W-1:0]   w_rem;
  logic                w_div_done;
  logic [DATA_W:0]     w_sum;
  logic [2*DATA_W-1:0] w_prod_fix;
  logic [DATA_W-1:0]   w_div_hi;
  logic [DATA_W-1:0]   w_div_lo;

  assign w_op        = muldiv_op_t'(req_op);
  assign w_accept    = req_valid && r_ready && !flush;
  assign w_signed    = op_is_signed(w_op);
  assign w_start_div = w_accept && op_is_div(w_op);
  assign w_last      = (r_cnt == CNT_W'(DATA_W - 1));
  assign w_mag_a     = (w_signed && src_a[DATA_W-1]) ? -src_a : src_a;
  assign w_mag_b     = (w_signed && src_b[DATA_W-1]) ? -src_b : src_b;

`ifdef MULDIV_FAST_MULT_EN
  logic                w_fast_mul;
  logic [2*DATA_W-1:0] w_ext_a;
  logic [2*DATA_W-1:0] w_ext_b;
  logic [2*DATA_W-1:0] w_fast_prod;

  // Low 2*DATA_W bits of the extended product are exact for both signednesses
  assign w_start_mul = 1'b0;
  assign w_fast_mul  = w_accept && op_is_mul(w_op);
  assign w_ext_a     = {{DATA_W{w_signed & src_a[DATA_W-1]}}, src_a};
  assign w_ext_b     = {{DATA_W{w_signed & src_b[DATA_W-1]}}, src_b};
  assign w_fast_prod = w_ext_a * w_ext_b;
`else
  assign w_start_mul = w_accept && op_is_mul(w_op);
`endif

  // Control FSM with registered handshake/status outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else if (flush) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
`ifdef MULDIV_FAST_MULT_EN
          r_done <= w_fast_mul;
`else
          r_done <= 1'b0;
`endif
          r_cnt  <= '0;
          if (w_start_mul) begin
            r_state <= MUL;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end else if (w_start_div) begin
            r_state <= DIV;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end else begin
            r_state <= IDLE;
          end
        end
        MUL, DIV: begin
          if (w_last) begin
            r_state <= FIN;
            r_done  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Operand capture at accept; shift-add multiplier iterates in MUL
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_src_a  <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
      r_op_div <= 1'b0;
    end else if (w_start_mul || w_start_div) begin
      r_mcand  <= w_mag_a;
      r_prod   <= {{DATA_W{1'b0}}, w_mag_b};
      r_src_a  <= src_a;
      r_neg_q  <= w_signed && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
      r_neg_r  <= w_signed && src_a[DATA_W-1];
      r_dbz    <= w_start_div && (src_b == '0);
      r_ovf    <= w_start_div && w_signed && (src_a == MIN_NEG) && (src_b == '1);
      r_op_div <= w_start_div;
    end else if ((r_state == MUL) && !flush) begin
      r_prod   <= {w_sum, r_prod[DATA_W-1:1]};
    end
  end

  div_restoring_core #(
    .DATA_W (DATA_W)
  ) u_div (
    .clk         (clk),
    .resetn      (resetn),
    .i_start     (w_start_div),
    .i_clear     (flush),
    .i_step      ((r_state == DIV) && !flush),
    .i_dividend  (w_mag_a),
    .i_divisor   (w_mag_b),
    .o_quotient  (w_quo),
    .o_remainder (w_rem),
    .o_done      (w_div_done)
  );

  // Multiplier partial sum and sign/special-case fix-up of the final results
  always_comb begin
    w_sum      = {1'b0, r_prod[2*DATA_W-1:DATA_W]} +
                 (r_prod[0] ? {1'b0, r_mcand} : {(DATA_W+1){1'b0}});
    w_prod_fix = r_neg_q ? -r_prod : r_prod;
    if (r_dbz) begin
      w_div_hi = r_src_a;
      w_div_lo = '1;
    end else if (r_ovf) begin
      w_div_hi = '0;
      w_div_lo = MIN_NEG;
    end else begin
      w_div_hi = r_neg_r ? -w_rem : w_rem;
      w_div_lo = r_neg_q ? -w_quo : w_quo;
    end
  end

  // HI/LO update: iterative results leaving FIN, or direct moves at accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if ((r_state == FIN) && !flush) begin
      if (r_op_div) begin
        if (w_div_done) begin
          r_hi <= w_div_hi;
          r_lo <= w_div_lo;
        end
      end else begin
        {r_hi, r_lo} <= w_prod_fix;
      end
    end else if (w_accept && (w_op == MD_MTHI)) begin
      r_hi <= src_a;
    end else if (w_accept && (w_op == MD_MTLO)) begin
      r_lo <= src_a;
`ifdef MULDIV_FAST_MULT_EN
    end else if (w_fast_mul) begin
      {r_hi, r_lo} <= w_fast_prod;
`endif
    end
  end

  assign req_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit (iterative multiply build).
module tb_hilo_muldiv_unit;
  import hilo_muldiv_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.DATA_W(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Issue one iterative op and follow it cycle by cycle until the result is visible.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input bit poke_busy);
    int done_cnt;
    int done_cyc;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    src_a     = a;
    src_b     = b;
    @(posedge clk); #1;
    req_valid = poke_busy;
    req_op    = MD_MTHI;
    src_a     = $urandom;
    src_b     = $urandom;
    done_cnt  = 0;
    done_cyc  = 0;
    for (int c = 1; c <= 34; c++) begin
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == 1) check({tag, " busy@1"}, {63'd0, busy}, 64'd1);
      if (c == 33) begin
        check({tag, " busy@33"}, {63'd0, busy}, 64'd1);
        check({tag, " ready@33"}, {63'd0, req_ready}, 64'd0);
        check({tag, " hi_old@33"}, {32'd0, hi}, {32'd0, m_hi});
        check({tag, " lo_old@33"}, {32'd0, lo}, {32'd0, m_lo});
      end
      if (c == 34) begin
        req_valid = 1'b0;
        check({tag, " busy@34"}, {63'd0, busy}, 64'd0);
        check({tag, " ready@34"}, {63'd0, req_ready}, 64'd1);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
      end
      if (c < 34) begin
        @(posedge clk); #1;
      end
    end
    check({tag, " done_count"}, 64'(done_cnt), 64'd1);
    check({tag, " done_cycle"}, 64'(done_cyc), 64'd33);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  initial begin
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    src_a     = '0;
    src_b     = '0;
    flush     = 1'b0;
    #12;
    check("rst hi", {32'd0, hi}, 64'd0);
    check("rst lo", {32'd0, lo}, 64'd0);
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst done", {63'd0, done}, 64'd0);
    check("rst ready", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    resetn = 1'b1;

    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    run_op("mult_m7x3", MD_MULT, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("div_m7d2", MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_dbz", MD_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b0);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu_1000d7", MD_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b1);
    run_op("mult_minmin", MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("div_7dm2", MD_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);

    // MTHI then MTLO in consecutive cycles
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = MD_MTHI;
    src_a     = 32'h0000_1234;
    @(posedge clk); #1;
    check("mthi hi", {32'd0, hi}, 64'h1234);
    check("mthi busy", {63'd0, busy}, 64'd0);
    req_op = MD_MTLO;
    src_a  = 32'h0000_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mtlo lo", {32'd0, lo}, 64'h5678);
    check("mtlo hi_keep", {32'd0, hi}, 64'h1234);
    check("mtlo busy", {63'd0, busy}, 64'd0);
    check("mtlo done", {63'd0, done}, 64'd0);
    m_hi = 32'h0000_1234;
    m_lo = 32'h0000_5678;

    // DIVU flushed at cycle 10
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = MD_DIVU;
    src_a     = 32'd50;
    src_b     = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("flush busy_before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", {63'd0, busy}, 64'd0);
    check("flush ready", {63'd0, req_ready}, 64'd1);
    check("flush hi", {32'd0, hi}, {32'd0, m_hi});
    check("flush lo", {32'd0, lo}, {32'd0, m_lo});
    req_valid = 1'b1;
    req_op    = MD_MTLO;
    src_a     = 32'h0000_ABCD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("flush mtlo", {32'd0, lo}, 64'hABCD);
    m_lo = 32'h0000_ABCD;
    repeat (40) @(posedge clk);
    #1;
    check("flush no_late_hi", {32'd0, hi}, {32'd0, m_hi});
    check("flush no_late_lo", {32'd0, lo}, {32'd0, m_lo});

    // flush together with a request drops it
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = MD_MTHI;
    src_a     = 32'h0000_DEAD;
    flush     = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    check("flush_req hi", {32'd0, hi}, {32'd0, m_hi});

    // asynchronous reset in the middle of a MULTU
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = MD_MULTU;
    src_a     = 32'd5;
    src_b     = 32'd6;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("areset hi", {32'd0, hi}, 64'd0);
    check("areset lo", {32'd0, lo}, 64'd0);
    check("areset busy", {63'd0, busy}, 64'd0);
    check("areset done", {63'd0, done}, 64'd0);
    check("areset ready", {63'd0, req_ready}, 64'd1);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    resetn = 1'b1;
    run_op("multu_5x6", MD_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
